// File: rtl/pattern_count_engine.sv
// Bit-pattern search accelerator: reads a pattern word and a byte string from data
// memory, counts within-byte, byte-hit and stream-wide matches, then writes the three counts back.
module pattern_count_engine #(
    parameter int DATA_W    = 8,
    parameter int PAT_W     = 5,
    parameter int NUM_BYTES = 32,
    parameter int ADDR_W    = 8,
    parameter int PAT_ADDR  = 32,
    parameter int RES_ADDR  = 33,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_PAT = 3'd1;
    localparam logic [2:0] SCAN   = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] WR_CTB = 3'd4;
    localparam logic [2:0] WR_CTO = 3'd5;
    localparam logic [2:0] WR_CTS = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam int EW    = $clog2(2 * DATA_W + 1);
    localparam int SUM_W = ((CNT_W > EW) ? CNT_W : EW) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [EW-1:0]    ONE_E    = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    ZERO_E   = {EW{1'b0}};
    localparam logic [IDX_W-1:0] ONE_I    = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    function automatic logic [EW-1:0] within_count(input logic [DATA_W-1:0] b,
                                                   input logic [PAT_W-1:0]  p);
        logic [EW-1:0] n;
        n = ZERO_E;
        for (int k = 0; k <= DATA_W - PAT_W; k++) begin
            if (b[k +: PAT_W] == p) n = n + ONE_E;
        end
        return n;
    endfunction

    // Windows of {prev, cur} that start in cur and end in prev; none exist when PAT_W is 1.
    function automatic logic [EW-1:0] boundary_count(input logic [DATA_W-1:0] prev,
                                                     input logic [DATA_W-1:0] cur,
                                                     input logic [PAT_W-1:0]  p);
        logic [2*DATA_W-1:0] w;
        logic [EW-1:0]       n;
        w = {prev, cur};
        n = ZERO_E;
        for (int k = DATA_W - PAT_W + 1; k < DATA_W; k++) begin
            if (w[k +: PAT_W] == p) n = n + ONE_E;
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [EW-1:0]    b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
        else                     return s[CNT_W-1:0];
    endfunction

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0]  ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
    logic              start_prev_q;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              start_rise_s, eval_s;
    logic [EW-1:0]     win_s, bnd_s;

    assign start_rise_s = start & ~start_prev_q;
    assign win_s        = within_count(mem_rd_data, pat_q);
    assign bnd_s        = boundary_count(prev_q, mem_rd_data, pat_q);
    assign eval_s       = ((state_q == SCAN) && (idx_q != {IDX_W{1'b0}})) || (state_q == DRAIN);

    // Next-state, counter accumulation and registered-output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pat_d      = pat_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        ctb_d      = ctb_q;
        cto_d      = cto_q;
        cts_d      = cts_q;
        ack_d      = 1'b0;
        addr_d     = {ADDR_W{1'b0}};
        wr_en_d    = 1'b0;
        wr_data_d  = {DATA_W{1'b0}};

        if (eval_s) begin
            ctb_d      = sat_add(ctb_q, win_s);
            cto_d      = sat_add(cto_q, (win_s != ZERO_E) ? ONE_E : ZERO_E);
            cts_d      = sat_add(cts_q, win_s + (prev_vld_q ? bnd_s : ZERO_E));
            prev_d     = mem_rd_data;
            prev_vld_d = 1'b1;
        end else begin
            prev_d     = prev_q;
            prev_vld_d = prev_vld_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_rise_s) begin
                    state_d    = RD_PAT;
                    addr_d     = ADDR_W'(PAT_ADDR);
                    ctb_d      = {CNT_W{1'b0}};
                    cto_d      = {CNT_W{1'b0}};
                    cts_d      = {CNT_W{1'b0}};
                    prev_d     = {DATA_W{1'b0}};
                    prev_vld_d = 1'b0;
                end else begin
                    ack_d = (state_q == DONE);
                end
            end
            RD_PAT: begin
                state_d = SCAN;
                idx_d   = {IDX_W{1'b0}};
            end
            SCAN: begin
                if (idx_q == {IDX_W{1'b0}}) pat_d = mem_rd_data[DATA_W-1 -: PAT_W];
                else                        pat_d = pat_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d  = idx_q + ONE_I;
                    addr_d = ADDR_W'(idx_q + ONE_I);
                end
            end
            DRAIN: begin
                // The last byte is folded in this cycle, so write its updated count.
                state_d   = WR_CTB;
                addr_d    = ADDR_W'(RES_ADDR);
                wr_en_d   = 1'b1;
                wr_data_d = DATA_W'(ctb_d);
            end
            WR_CTB: begin
                state_d   = WR_CTO;
                addr_d    = ADDR_W'(RES_ADDR + 1);
                wr_en_d   = 1'b1;
                wr_data_d = DATA_W'(cto_q);
            end
            WR_CTO: begin
                state_d   = WR_CTS;
                addr_d    = ADDR_W'(RES_ADDR + 2);
                wr_en_d   = 1'b1;
                wr_data_d = DATA_W'(cts_q);
            end
            WR_CTS: begin
                state_d = DONE;
                ack_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered memory-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= {IDX_W{1'b0}};
            pat_q        <= {PAT_W{1'b0}};
            prev_q       <= {DATA_W{1'b0}};
            prev_vld_q   <= 1'b0;
            ctb_q        <= {CNT_W{1'b0}};
            cto_q        <= {CNT_W{1'b0}};
            cts_q        <= {CNT_W{1'b0}};
            start_prev_q <= 1'b0;
            ack_q        <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wr_en_q      <= 1'b0;
            wr_data_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pat_q        <= pat_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            ctb_q        <= ctb_d;
            cto_q        <= cto_d;
            cts_q        <= cts_d;
            start_prev_q <= start;
            ack_q        <= ack_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign ack         = ack_q;
    assign mem_addr    = addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;

endmodule
